// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline from decode through STAGES registers (stage 1 = E).
// Each stage supports flush and stall. Holds propagate backwards, and a bubble is
// inserted below a held stage.
// Optional feature, enabled by defining CTRL_PIPE_MC_EN: a multi-cycle op (bit MC_BIT set)
// occupies stage 1 for MC_LAT cycles.
module ctrl_pipe #(
    parameter int W      = 16,
    parameter int STAGES = 3,
    parameter int MC_BIT = 15,
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          ctrl_d,
    input  logic                  valid_d,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   ctrl_q,
    output logic [STAGES-1:0]     valid_q,
    output logic                  stall_d,
    output logic                  mc_busy
);

    // hold[i] applies to stage i.
    // hold[0] (decode) and hold[STAGES+1] (past the end) are constant 0,
    // so stage 1 and the last stage need no special case.
    logic [STAGES+1:0] hold;
    logic              mc_hold;

    logic [W-1:0]      ctrl_r    [STAGES];
    logic [STAGES-1:0] valid_r;
    logic [W-1:0]      prev_ctrl [STAGES];
    logic [STAGES-1:0] prev_valid;

    // Backward hold chain: a stage holds if it is stalled or anything below it holds.
    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        hold = '0;
        for (int i = STAGES; i >= 1; i--) begin
            hold[i] = stall[i-1] | hold[i+1] | ((i == 1) & mc_hold);
        end
    end

    // Source for each stage's load: decode feeds stage 1, stage j feeds stage j+1.
    always_comb begin
        prev_ctrl[0]  = ctrl_d;
        prev_valid[0] = valid_d;
        for (int j = 1; j < STAGES; j++) begin
            prev_ctrl[j]  = ctrl_r[j-1];
            prev_valid[j] = valid_r[j-1];
        end
    end

    // Stage registers: flush > hold > bubble-below-held-stage > advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the stage array is a handful of control registers, not RAM, so it is
            // reset along with everything else to guarantee an empty pipeline.
            for (int j = 0; j < STAGES; j++) ctrl_r[j] <= '0;
            valid_r <= '0;
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                // NOTE: non-blocking assignments, so every stage samples its neighbour's old value.
                if (flush[j]) begin
                    ctrl_r[j]  <= '0;
                    valid_r[j] <= 1'b0;
                end else if (hold[j+1]) begin
                    ctrl_r[j]  <= ctrl_r[j];
                    valid_r[j] <= valid_r[j];
                end else if (hold[j]) begin
                    ctrl_r[j]  <= '0;
                    valid_r[j] <= 1'b0;
                end else begin
                    ctrl_r[j]  <= prev_ctrl[j];
                    valid_r[j] <= prev_valid[j];
                end
            end
        end
    end

`ifdef CTRL_PIPE_MC_EN
    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    logic [CW-1:0] cnt;
    logic          ext_hold1;

    // Stage 1 is also held by an external stall at or below it; that freezes the countdown.
    assign ext_hold1 = stall[0] | hold[2];

    // Multi-cycle countdown.
    // It is armed when a valid flagged word enters stage 1, and cleared by a flush of stage 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush[0]) begin
            cnt <= '0;
        end else if (!hold[1] && valid_d && ctrl_d[MC_BIT]) begin
            cnt <= CW'(MC_LAT - 1);
        end else if (cnt != '0 && !ext_hold1) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign mc_hold = (cnt != '0);
`else
    // The multi-cycle parameters have no effect in this build.
    localparam int unused_mc_cfg = MC_BIT + MC_LAT;

    assign mc_hold = 1'b0;
`endif

    // Flatten the stage array onto the output bus; stage 1 occupies the low bits.
    always_comb begin
        ctrl_q = '0;
        for (int j = 0; j < STAGES; j++) begin
            ctrl_q[j*W +: W] = ctrl_r[j];
        end
    end

    assign valid_q = valid_r;
    assign stall_d = hold[1];
    assign mc_busy = mc_hold;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and random checks of ctrl_pipe against a behavioural model.
// The model follows CTRL_PIPE_MC_EN in the same way the design does.
module tb_ctrl_pipe;

    localparam int W      = 16;
    localparam int S      = 3;
    localparam int MC_BIT = 15;
    localparam int MC_LAT = 4;
`ifdef CTRL_PIPE_MC_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [W-1:0]     ctrl_d = '0;
    logic             valid_d = 1'b0;
    logic [S-1:0]     stall = '0;
    logic [S-1:0]     flush = '0;
    logic [S*W-1:0]   ctrl_q;
    logic [S-1:0]     valid_q;
    logic             stall_d;
    logic             mc_busy;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_pipe #(.W(W), .STAGES(S), .MC_BIT(MC_BIT), .MC_LAT(MC_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_d  (ctrl_d),
        .valid_d (valid_d),
        .stall   (stall),
        .flush   (flush),
        .ctrl_q  (ctrl_q),
        .valid_q (valid_q),
        .stall_d (stall_d),
        .mc_busy (mc_busy)
    );

    always #5 clk = ~clk;

    // Reference model: per-stage contents plus the number of extra cycles the
    // word in stage 1 still has to spend there.
    logic [W-1:0] m_ctrl  [1:S];
    bit           m_valid [1:S];
    int           m_rem;

    function automatic bit m_hold(int i);
        if (i > S) return 1'b0;
        return stall[i-1] | m_hold(i + 1) | (i == 1 && MC_EN && m_rem > 0);
    endfunction

    function automatic logic [S*W-1:0] m_ctrl_q();
        logic [S*W-1:0] r = '0;
        for (int i = 1; i <= S; i++) r[(i-1)*W +: W] = m_ctrl[i];
        return r;
    endfunction

    function automatic logic [S-1:0] m_valid_q();
        logic [S-1:0] r = '0;
        for (int i = 1; i <= S; i++) r[i-1] = m_valid[i];
        return r;
    endfunction

    task automatic model_step();
        bit           h [1:S+1];
        logic [W-1:0] oc [1:S];
        bit           ov [1:S];
        if (!rst) begin
            for (int i = 1; i <= S; i++) begin
                m_ctrl[i]  = '0;
                m_valid[i] = 1'b0;
            end
            m_rem = 0;
            return;
        end
        for (int i = 1; i <= S + 1; i++) h[i] = m_hold(i);
        for (int i = 1; i <= S; i++) begin
            oc[i] = m_ctrl[i];
            ov[i] = m_valid[i];
        end
        for (int i = 1; i <= S; i++) begin
            if (flush[i-1]) begin
                m_ctrl[i] = '0; m_valid[i] = 1'b0;
            end else if (h[i]) begin
                m_ctrl[i] = oc[i]; m_valid[i] = ov[i];
            end else if (i > 1 && h[i-1]) begin
                m_ctrl[i] = '0; m_valid[i] = 1'b0;
            end else if (i == 1) begin
                m_ctrl[i] = ctrl_d; m_valid[i] = valid_d;
            end else begin
                m_ctrl[i] = oc[i-1]; m_valid[i] = ov[i-1];
            end
        end
        if (MC_EN) begin
            if (flush[0]) m_rem = 0;
            else if (!h[1] && valid_d && ctrl_d[MC_BIT]) m_rem = MC_LAT - 1;
            else if (m_rem > 0 && !(stall[0] | h[2])) m_rem = m_rem - 1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] c, input logic v, input logic [S-1:0] s,
                         input logic [S-1:0] f);
        ctrl_d  = c;
        valid_d = v;
        stall   = s;
        flush   = f;
    endtask

    // Compare against the model mid-cycle, then advance one edge.
    task automatic tick();
        @(negedge clk);
        check("ctrl_q",  64'(ctrl_q),  64'(m_ctrl_q()));
        check("valid_q", 64'(valid_q), 64'(m_valid_q()));
        check("stall_d", 64'(stall_d), 64'(m_hold(1)));
        check("mc_busy", 64'(mc_busy), 64'(MC_EN && m_rem > 0));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        model_step();
        @(posedge clk); #1;

        // Reset held with random inputs.
        for (int k = 0; k < 3; k++) begin
            drive(W'($urandom), 1'($urandom), S'($urandom), S'($urandom));
            #1;
            check("rst_stall_d", 64'(stall_d), 64'(|stall));
            tick();
        end
        drive('0, 1'b0, '0, '0);
        rst = 1'b1;
        check("rst_valid", 64'(valid_q), 64'(0));
        check("rst_ctrl",  64'(ctrl_q),  64'(0));
        check("rst_busy",  64'(mc_busy), 64'(0));

        // Latency: stage 3 shows the word two cycles after stage 1.
        drive(16'h0001, 1'b1, '0, '0); tick();
        check("lat_s1", 64'(ctrl_q[15:0]), 64'h1);
        drive(16'h0002, 1'b1, '0, '0); tick();
        drive(16'h0003, 1'b1, '0, '0); tick();
        check("lat_s3", 64'(ctrl_q[47:32]), 64'h1);
        check("lat_valid", 64'(valid_q), 64'b111);

        // Stall M with A, B, C in flight.
        drive(16'h0011, 1'b1, '0, '0); tick();
        drive(16'h0022, 1'b1, '0, '0); tick();
        drive(16'h0033, 1'b1, '0, '0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(16'h0044, 1'b1, 3'b010, '0);
            #1;
            check("stm_stall_d", 64'(stall_d), 64'h1);
            tick();
            check("stm_ctrl",  64'(ctrl_q),  64'h0000_0022_0033);
            check("stm_valid", 64'(valid_q), 64'b011);
        end
        drive(16'h0044, 1'b1, '0, '0); tick();
        check("stm_resume", 64'(ctrl_q), 64'h0022_0033_0044);

        // Flush E together with stall M.
        drive(16'h0055, 1'b1, 3'b010, 3'b001);
        #1;
        check("fle_stall_d", 64'(stall_d), 64'h1);
        tick();
        check("fle_s1_valid", 64'(valid_q[0]), 64'h0);
        check("fle_s1_ctrl",  64'(ctrl_q[15:0]), 64'h0);
        check("fle_s2_ctrl",  64'(ctrl_q[31:16]), 64'h0033);
        drive('0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) tick();

`ifdef CTRL_PIPE_MC_EN
        // Multi-cycle word occupies stage 1 for MC_LAT cycles.
        drive(16'h8005, 1'b1, '0, '0); tick();
        drive(16'h0006, 1'b1, '0, '0);
        for (int k = 0; k < MC_LAT - 1; k++) begin
            #1;
            check("mc_busy_on", 64'(mc_busy), 64'h1);
            check("mc_stall_d", 64'(stall_d), 64'h1);
            check("mc_s1", 64'(ctrl_q[15:0]), 64'h8005);
            check("mc_s2_bubble", 64'(valid_q[1]), 64'h0);
            tick();
        end
        check("mc_busy_off", 64'(mc_busy), 64'h0);
        check("mc_stall_off", 64'(stall_d), 64'h0);
        check("mc_s1_last", 64'(ctrl_q[15:0]), 64'h8005);
        tick();
        check("mc_s2_word", 64'(ctrl_q[31:0]), 64'h8005_0006);
        drive('0, 1'b0, '0, '0); tick();
        check("mc_s2_next", 64'(ctrl_q[31:16]), 64'h0006);
        for (int k = 0; k < 3; k++) tick();

        // Multi-cycle word flushed on its second cycle in stage 1.
        drive(16'h8005, 1'b1, '0, '0); tick();
        drive(16'h0006, 1'b1, '0, '0); tick();
        drive(16'h0006, 1'b1, '0, 3'b001);
        #1;
        check("mcf_stall_d", 64'(stall_d), 64'h1);
        tick();
        check("mcf_busy", 64'(mc_busy), 64'h0);
        check("mcf_s1_valid", 64'(valid_q[0]), 64'h0);
        drive(16'h0006, 1'b1, '0, '0);
        #1;
        check("mcf_stall_off", 64'(stall_d), 64'h0);
        tick();
        check("mcf_s1", 64'(ctrl_q[15:0]), 64'h0006);
        drive('0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) tick();
`else
        // Without the feature the flagged word flows like any other.
        drive(16'h8005, 1'b1, '0, '0); tick();
        check("nomc_busy", 64'(mc_busy), 64'h0);
        check("nomc_s1", 64'(ctrl_q[15:0]), 64'h8005);
        drive('0, 1'b0, '0, '0);
        #1;
        check("nomc_stall_d", 64'(stall_d), 64'h0);
        tick();
        check("nomc_s2", 64'(ctrl_q[31:16]), 64'h8005);
        tick();
        check("nomc_s3", 64'(ctrl_q[47:32]), 64'h8005);
`endif

        // Random traffic, including an asynchronous reset mid-run.
        for (int k = 0; k < 400; k++) begin
            logic [S-1:0] s;
            logic [S-1:0] f;
            for (int b = 0; b < S; b++) begin
                s[b] = ($urandom_range(5) == 0);
                f[b] = ($urandom_range(7) == 0);
            end
            drive(W'($urandom), 1'($urandom), s, f);
            if (k == 200) begin
                #2 rst = 1'b0;
                #1;
                check("arst_valid", 64'(valid_q), 64'h0);
                check("arst_ctrl",  64'(ctrl_q),  64'h0);
                check("arst_busy",  64'(mc_busy), 64'h0);
                model_step();
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
